// File: rtl/dino_pkg.sv
// dino_pkg: shared game states and screen geometry for the game controller.
package dino_pkg;
  typedef enum logic [1:0] {IDLE, RUN, CRASH} state_t;
  localparam logic [8:0] GROUND_ROW = 9'd402;
  localparam logic [9:0] H_VISIBLE  = 10'd640;
  localparam logic [8:0] V_VISIBLE  = 9'd480;
endpackage

// File: rtl/fresh_edge.sv
// fresh_edge: one-cycle frame-end pulse on the falling edge of the fresh strobe.
// Ports: CLK, RESET (async, active-high), fresh (frame strobe), fe (frame-end pulse).
module fresh_edge (
  input  logic CLK,
  input  logic RESET,
  input  logic fresh,
  output logic fe
);
  logic fresh_q, armed;
  // armed blocks a falling edge until fresh has actually been seen high after reset
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      fresh_q <= 1'b1;
      armed   <= 1'b0;
    end else begin
      fresh_q <= fresh;
      armed   <= armed | fresh;
    end
  assign fe = armed & fresh_q & ~fresh;
endmodule

// File: rtl/game_ctrl.sv
// game_ctrl: dino game state machine, crash detection, score and pixel compositing.
// Ports: CLK, RESET (async, active-high), fresh, button_jump, row_addr, col_addr,
//   dino_px, cactus_px -> game_status, crashed, px_out (1-cycle latency), score.
// Score counter present only when GAME_CTRL_SCORE_EN is defined; otherwise score = 0.
module game_ctrl
  import dino_pkg::*;
#(
  parameter int OVERLAP_THRESH = 4,
  parameter int SCORE_W        = 16
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               fresh,
  input  logic               button_jump,
  input  logic [8:0]         row_addr,
  input  logic [9:0]         col_addr,
  input  logic               dino_px,
  input  logic               cactus_px,
  output logic               game_status,
  output logic               crashed,
  output logic               px_out,
  output logic [SCORE_W-1:0] score
);
  localparam logic [7:0] THRESH = 8'(OVERLAP_THRESH);
  state_t     state, state_n;
  logic       fe, vis, hit, hit_frame;
  logic [7:0] ovl;
  fresh_edge u_edge (.CLK(CLK), .RESET(RESET), .fresh(fresh), .fe(fe));
  assign vis       = (row_addr < V_VISIBLE) && (col_addr < H_VISIBLE);
  assign hit       = (state == RUN) && dino_px && cactus_px && vis;
  assign hit_frame = ovl >= THRESH;
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) state <= IDLE;
    else       state <= state_n;
  always_comb begin
    state_n     = state;
    game_status = state == RUN;
    crashed     = state == CRASH;
    if (fe)
      state_n = state == IDLE ? (button_jump ? RUN : IDLE) :
                state == RUN  ? (hit_frame ? CRASH : RUN) :
                                (button_jump ? CRASH : IDLE);
  end
  // clearing on fe also drops a hit landing on the fe cycle from both frames
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) ovl <= '0;
    else       ovl <= fe ? '0 : (hit && ovl != 8'hff) ? ovl + 8'd1 : ovl;
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) px_out <= 1'b0;
    else       px_out <= vis & ((dino_px | cactus_px | (row_addr == GROUND_ROW)) ^ (state == CRASH));
`ifdef GAME_CTRL_SCORE_EN
  logic [SCORE_W-1:0] score_q;
  always_ff @(posedge CLK or posedge RESET)
    if (RESET)                                     score_q <= '0;
    else if (fe && state == IDLE && button_jump)   score_q <= '0;
    else if (fe && state == RUN && !hit_frame && score_q != '1) score_q <= score_q + 1'b1;
  assign score = score_q;
`else
  assign score = '0;
`endif
endmodule

// File: tb/tb_game_ctrl.sv
// tb_game_ctrl: directed stimulus for game_ctrl against a frame-level game model.
module tb_game_ctrl;
  logic       CLK = 0, RESET = 1, fresh = 0, button_jump = 0, dino_px = 0, cactus_px = 0;
  logic [8:0] row_addr = 0;
  logic [9:0] col_addr = 0;
  logic       game_status, crashed, px_out;
  logic [3:0] score;
  int n_chk = 0, n_fail = 0;
`ifdef GAME_CTRL_SCORE_EN
  localparam bit SEN = 1'b1;
`else
  localparam bit SEN = 1'b0;
`endif
  game_ctrl #(.OVERLAP_THRESH(4), .SCORE_W(4)) dut (
    .CLK(CLK), .RESET(RESET), .fresh(fresh), .button_jump(button_jump),
    .row_addr(row_addr), .col_addr(col_addr), .dino_px(dino_px), .cactus_px(cactus_px),
    .game_status(game_status), .crashed(crashed), .px_out(px_out), .score(score)
  );
  always #5 CLK = ~CLK;
  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  // model: 0 = idle, 1 = running, 2 = crashed; hits = overlaps counted this frame
  int   m_mode, m_hits, m_score;
  logic m_prev, m_armed, m_px, m_vis, m_fe;
  assign m_vis = row_addr < 480 && col_addr < 640;
  assign m_fe  = m_armed && m_prev && !fresh;
  always @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      m_mode <= 0; m_hits <= 0; m_score <= 0; m_prev <= 1; m_armed <= 0; m_px <= 0;
    end else begin
      m_prev  <= fresh;
      m_armed <= m_armed | fresh;
      m_px    <= m_vis && ((dino_px || cactus_px || row_addr == 402) != (m_mode == 2));
      if (m_fe) begin
        m_hits <= 0;
        if (m_mode == 0 && button_jump) begin m_mode <= 1; m_score <= 0; end
        else if (m_mode == 1 && m_hits >= 4) m_mode <= 2;
        else if (m_mode == 1) m_score <= m_score < 15 ? m_score + 1 : 15;
        else if (m_mode == 2 && !button_jump) m_mode <= 0;
      end else if (m_mode == 1 && dino_px && cactus_px && m_vis && m_hits < 255)
        m_hits <= m_hits + 1;
    end
  end
  always @(negedge CLK)
    if (!RESET) begin
      chk("game_status", game_status, m_mode == 1);
      chk("crashed", crashed, m_mode == 2);
      chk("px_out", px_out, m_px);
      chk("score", score, SEN ? m_score : 0);
    end
  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask
  task automatic frame(input int hits, input bit btn, input bit fe_hit);
    button_jump = btn; fresh = 1; cyc(2);
    row_addr = 9'd200; col_addr = 10'd200;
    for (int i = 0; i < hits; i++) begin dino_px = 1; cactus_px = 1; cyc(1); end
    dino_px = fe_hit; cactus_px = fe_hit; fresh = 0; cyc(1);
    dino_px = 0; cactus_px = 0;
  endtask
  task automatic px(input int r, input int c, input bit d, input int exp, input string nm);
    row_addr = 9'(r); col_addr = 10'(c); dino_px = d; cyc(1);
    chk(nm, px_out, exp);
    dino_px = 0;
  endtask
  initial begin
    #1;
    chk("rst_status", game_status, 0); chk("rst_crashed", crashed, 0);
    chk("rst_px", px_out, 0); chk("rst_score", score, 0);
    cyc(2); RESET = 0;
    button_jump = 1; cyc(4);
    chk("no_fe_after_reset", game_status, 0);
    button_jump = 0;
    px(100, 100, 1, 1, "px_dino"); px(402, 639, 0, 1, "px_ground");
    px(402, 700, 0, 0, "px_offscreen"); px(300, 300, 0, 0, "px_blank");
    frame(0, 1, 0);
    chk("start_run", game_status, 1); chk("start_score", score, 0);
    frame(3, 0, 0);
    chk("thr3_nocrash", crashed, 0); chk("score1", score, SEN ? 1 : 0);
    frame(3, 0, 1); frame(3, 0, 0);
    chk("fe_pixel_excluded", crashed, 0);
    repeat (7) frame(0, 0, 0);
    chk("score10", score, SEN ? 10 : 0);
    frame(4, 0, 0);
    chk("thr4_crash", crashed, 1); chk("crash_not_running", game_status, 0);
    chk("crash_score_held", score, SEN ? 10 : 0);
    px(100, 100, 1, 0, "px_dino_crash"); px(402, 639, 0, 0, "px_ground_crash");
    px(402, 700, 0, 0, "px_offscreen_crash"); px(300, 300, 0, 1, "px_blank_crash");
    repeat (5) frame(0, 1, 0);
    chk("held_btn_stays_crash", crashed, 1);
    frame(0, 0, 0);
    chk("release_idle_crashed", crashed, 0); chk("release_idle_status", game_status, 0);
    frame(0, 1, 0);
    chk("rerun", game_status, 1); chk("rerun_score", score, 0);
    repeat (20) frame(0, 0, 0);
    chk("score_sat", score, SEN ? 15 : 0);
    fresh = 1; row_addr = 9'd200; col_addr = 10'd200; cyc(2);
    repeat (3) begin dino_px = 1; cactus_px = 1; cyc(1); end
    dino_px = 0; cactus_px = 0; row_addr = 9'd402; col_addr = 10'd10; cyc(1);
    chk("px_before_reset", px_out, 1);
    #2 RESET = 1; fresh = 0;
    #1;
    chk("async_status", game_status, 0); chk("async_crashed", crashed, 0);
    chk("async_px", px_out, 0); chk("async_score", score, 0);
    cyc(2); RESET = 0; button_jump = 1; cyc(5);
    chk("no_spurious_fe", game_status, 0);
    frame(0, 1, 0);
    chk("restart_after_reset", game_status, 1);
    cyc(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
